// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: radix-2 Booth sequencing controller with the multiplier-side
// datapath (M, Q, q_1, step counter).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; accumulator cleared on the accepting edge
// EVAL  | decode {Q[0], q_1}; load acc_q +/- M into the accumulator if needed
// SHIFT | arithmetic right shift of {acc, Q, q_1}; count one Booth step
// DONE  | capture {acc_q, Q} into product and raise the done pulse
//
// The accumulator register sits outside this block. acc_din and acc_ld are
// combinational because acc_din depends on acc_q, which changes on the edge
// entering EVAL.

module booth_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       multiplicand,
    input  logic [WIDTH-1:0]       multiplier,
    input  logic [WIDTH-1:0]       acc_q,
    input  logic                   acc_sd,
    output logic                   acc_clr,
    output logic                   acc_ld,
    output logic                   acc_en,
    output logic [WIDTH-1:0]       acc_din,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_1;
    logic [CW-1:0]    count;

    // Sequencer: operand capture, Booth step bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            m_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        q_1   <= 1'b0;
                        count <= COUNT_INIT;
                        busy  <= 1'b1;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    // acc_sd is the accumulator LSB before this edge's shift.
                    q_reg <= {acc_sd, q_reg[WIDTH-1:1]};
                    q_1   <= q_reg[0];
                    count <= count - COUNT_LAST;
                    if (count == COUNT_LAST) begin
                        state <= DONE;
                    end else begin
                        state <= EVAL;
                    end
                end
                DONE: begin
                    product <= {acc_q, q_reg};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Accumulator controls: clear on acceptance, add/subtract in EVAL, shift in SHIFT.
    always_comb begin
        acc_clr = reset | ((state == IDLE) & start);
        acc_ld  = 1'b0;
        acc_en  = 1'b0;
        acc_din = '0;
        case (state)
            EVAL: begin
                case ({q_reg[0], q_1})
                    2'b10: begin
                        acc_ld  = 1'b1;
                        acc_din = acc_q - m_reg;
                    end
                    2'b01: begin
                        acc_ld  = 1'b1;
                        acc_din = acc_q + m_reg;
                    end
                    default: begin
                        acc_ld  = 1'b0;
                    end
                endcase
            end
            SHIFT: begin
                acc_en = 1'b1;
            end
            default: begin
                acc_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: directed-vector bench for booth_seq_ctrl with a
// behavioural accumulator shift register and a queue-based scoreboard.

module tb_booth_seq_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic [W-1:0]   acc_q;
    logic           acc_sd;
    logic           acc_clr;
    logic           acc_ld;
    logic           acc_en;
    logic [W-1:0]   acc_din;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .acc_q        (acc_q),
        .acc_sd       (acc_sd),
        .acc_clr      (acc_clr),
        .acc_ld       (acc_ld),
        .acc_en       (acc_en),
        .acc_din      (acc_din),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    // Accumulator arithmetic shift register.
    always_ff @(posedge clk) begin
        if (acc_clr)     acc_q <= '0;
        else if (acc_ld) acc_q <= acc_din;
        else if (acc_en) acc_q <= {acc_q[W-1], acc_q[W-1:1]};
    end
    assign acc_sd = acc_q[0];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    int ld_cnt   = 0;
    int en_cnt   = 0;
    int viol_ld_en = 0;
    int viol_din   = 0;

    typedef struct {
        logic [2*W-1:0] prod;
        int             start_edge;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pops an expected result on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (acc_ld) ld_cnt++;
            if (acc_en) en_cnt++;
            if (acc_ld && acc_en) viol_ld_en++;
            if (!acc_ld && acc_din != '0) viol_din++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(product), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("product", 32'(product), 32'(e.prod));
                    chk("done_latency", 32'(cyc - e.start_edge), 32'd17);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_wait", 32'(exp_q.size()), 32'd0);
    endtask

    // Issue one start pulse; returns at the negedge right after acceptance.
    task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [2*W-1:0] req, input bit push);
        wait_idle();
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        if (push) exp_q.push_back('{prod: req, start_edge: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    initial begin
        int s;
        int p;
        logic [W-1:0] rm, rq;

        reset = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    {31'b0, busy},    32'd0);
        chk("rst_done",    {31'b0, done},    32'd0);
        chk("rst_product", 32'(product),     32'd0);
        chk("rst_acc_ld",  {31'b0, acc_ld},  32'd0);
        chk("rst_acc_en",  {31'b0, acc_en},  32'd0);
        chk("rst_acc_din", 32'(acc_din),     32'd0);
        chk("rst_acc_clr", {31'b0, acc_clr}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Directed products.
        do_op(8'h03, 8'h05, 16'h000F, 1'b1);
        wait_drain();
        chk("busy_in_done_cycle", {31'b0, busy}, 32'd0);
        do_op(8'hF9, 8'h06, 16'hFFD6, 1'b1);
        wait_drain();
        do_op(8'h7F, 8'h80, 16'hC080, 1'b1);
        wait_drain();
        do_op(8'hFF, 8'hFF, 16'h0001, 1'b1);
        wait_drain();

        // Zero multiplier: no loads, eight shifts; a start pulse mid-op is ignored.
        wait_idle();
        ld_cnt = 0;
        en_cnt = 0;
        do_op(8'h9C, 8'h00, 16'h0000, 1'b1);
        repeat (3) @(negedge clk);
        multiplicand = 8'h7F;
        multiplier   = 8'h01;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        chk("zero_ld_count", 32'(ld_cnt), 32'd0);
        chk("zero_en_count", 32'(en_cnt), 32'd8);
        repeat (25) @(negedge clk);

        // start held high across three operations, operands changed mid-op.
        wait_idle();
        s = cyc + 1;
        multiplicand = 8'h05;
        multiplier   = 8'h07;
        start        = 1'b1;
        exp_q.push_back('{prod: 16'h0023, start_edge: s});
        exp_q.push_back('{prod: 16'hFFEE, start_edge: s + 18});
        exp_q.push_back('{prod: 16'hFF00, start_edge: s + 36});
        repeat (3) @(negedge clk);
        multiplicand = 8'hFE;
        multiplier   = 8'h09;
        while (cyc < s + 20) @(negedge clk);
        multiplicand = 8'h10;
        multiplier   = 8'hF0;
        while (cyc < s + 36) @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);

        // Reset asserted at E6 of an operation.
        do_op(8'h55, 8'h33, 16'h0000, 1'b0);
        s = cyc;
        while (cyc < s + 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy",    {31'b0, busy}, 32'd0);
        chk("midrst_acc_q",   32'(acc_q),    32'd0);
        chk("midrst_done",    {31'b0, done}, 32'd0);
        chk("midrst_product", 32'(product),  32'd0);
        repeat (25) @(negedge clk);
        do_op(8'h0C, 8'hFD, 16'hFFDC, 1'b1);
        wait_drain();

        // Random pairs against a signed reference.
        for (int i = 0; i < 100; i++) begin
            rm = 8'($urandom_range(0, 255));
            if (rm == 8'h80) rm = 8'h81;
            rq = 8'($urandom_range(0, 255));
            p  = $signed(rm) * $signed(rq);
            do_op(rm, rq, p[15:0], 1'b1);
            wait_drain();
        end

        repeat (5) @(negedge clk);
        chk("ld_and_en_together", 32'(viol_ld_en), 32'd0);
        chk("din_without_ld",     32'(viol_din),   32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
